fpu_scheduler: RTL and testbench

FPU_SCHEDULER -- requirements
Module: fpu_scheduler

---
 rtl/fpu_scheduler_if.sv | 43 ++++
 rtl/fpu_scheduler.sv | 111 +++++++++++
 tb/tb_fpu_scheduler.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/fpu_scheduler_if.sv
// rtl/fpu_scheduler_if.sv - Requester, response and fixed-point unit signals of the FPU scheduler
interface fpu_scheduler_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ready;
    logic             req1_valid;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ready;
    logic             resp0_valid;
    logic             resp1_valid;
    logic [WIDTH-1:0] resp_data;
    logic             resp_error;
    logic [WIDTH-1:0] fpu_operand_1;
    logic [WIDTH-1:0] fpu_operand_2;
    logic [1:0]       fpu_operation;
    logic [WIDTH-1:0] fpu_result;
    logic             fpu_ready;

    // Environment side: requesters plus the fixed-point unit.
    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  resp0_valid, resp1_valid, resp_data, resp_error,
        input  fpu_operand_1, fpu_operand_2, fpu_operation,
        output fpu_result, fpu_ready
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req0_ready, req1_ready,
        output resp0_valid, resp1_valid, resp_data, resp_error,
        output fpu_operand_1, fpu_operand_2, fpu_operation,
        input  fpu_result, fpu_ready
    );
endinterface

// File: rtl/fpu_scheduler.sv
// rtl/fpu_scheduler.sv - Round-robin scheduler sharing one fixed-point unit between two requesters
module fpu_scheduler #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic           clk,
    input  logic           reset,
    fpu_scheduler_if.slave bus
);
    localparam logic [1:0] FPU_ADD  = 2'd0;
    localparam logic [1:0] FPU_MUL  = 2'd2;
    localparam logic [1:0] FPU_SQRT = 2'd3;
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE, FLUSH} state_t;

    state_t           state, state_nx;
    logic             ptr;
    logic             owner;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] data_q;
    logic             error_q;
    logic             any_valid;
    logic             grant_id;
    logic             accept;
    logic             multi_cycle;
    logic             ready_seen;
    logic             timed_out;

    assign bus.resp_data  = data_q;
    assign bus.resp_error = error_q;

    always_comb begin
        any_valid   = bus.req0_valid | bus.req1_valid;
        grant_id    = (bus.req0_valid & bus.req1_valid) ? ptr : bus.req1_valid;
        accept      = (state == IDLE) & any_valid;
        multi_cycle = (op_q == FPU_MUL) | (op_q == FPU_SQRT);
        // MUL/SQRT may still show ready from the previous phase in their first cycle.
        ready_seen  = (state == ISSUE) & bus.fpu_ready & ~(multi_cycle & (cnt == '0));
        timed_out   = (state == ISSUE) & ~ready_seen & (cnt == CNT_LAST);

        state_nx          = state;
        bus.req0_ready    = 1'b0;
        bus.req1_ready    = 1'b0;
        bus.resp0_valid   = 1'b0;
        bus.resp1_valid   = 1'b0;
        bus.fpu_operation = FPU_ADD;
        bus.fpu_operand_1 = '0;
        bus.fpu_operand_2 = '0;

        case (state)
            IDLE: begin
                bus.req0_ready = reset & any_valid & ~grant_id;
                bus.req1_ready = reset & any_valid & grant_id;
                if (accept) state_nx = ISSUE;
            end
            ISSUE: begin
                bus.fpu_operation = op_q;
                bus.fpu_operand_1 = a_q;
                bus.fpu_operand_2 = b_q;
                if (ready_seen | timed_out) state_nx = DONE;
            end
            DONE: begin
                bus.resp0_valid = ~owner;
                bus.resp1_valid = owner;
                state_nx        = FLUSH;
            end
            FLUSH: begin
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ptr     <= 1'b0;
            owner   <= 1'b0;
            op_q    <= FPU_ADD;
            a_q     <= '0;
            b_q     <= '0;
            cnt     <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q  <= grant_id ? bus.req1_op : bus.req0_op;
                a_q   <= grant_id ? bus.req1_a  : bus.req0_a;
                b_q   <= grant_id ? bus.req1_b  : bus.req0_b;
                owner <= grant_id;
                ptr   <= ~grant_id;
                cnt   <= '0;
            end else if ((state == ISSUE) && !ready_seen && !timed_out) begin
                cnt <= cnt + 1'b1;
            end
            if (ready_seen) begin
                data_q  <= bus.fpu_result;
                error_q <= 1'b0;
            end else if (timed_out) begin
                data_q  <= '0;
                error_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fpu_scheduler.sv
// tb/tb_fpu_scheduler.sv - Directed-vector bench for fpu_scheduler
module tb_fpu_scheduler;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 64;
    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_MUL  = 2'd2;
    localparam logic [1:0] OP_SQRT = 2'd3;

    typedef struct {
        logic        req;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          delay;   // ISSUE cycle index where unit raises ready; -1 = never
        logic [31:0] result;
        int          lat;     // cycles from accept cycle to response cycle
        logic        err;
        logic [31:0] data;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[6];

    always #5 clk = ~clk;

    fpu_scheduler_if #(.WIDTH(WIDTH)) bus ();

    fpu_scheduler #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic r, input logic v, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b);
        if (r) begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int   k;
        logic got;
        logic hold_ok;
        set_req(v.req, 1'b1, v.op, v.a, v.b);
        #1;
        check("accept_ready", v.req ? bus.req1_ready : bus.req0_ready, 1);
        check("other_ready", v.req ? bus.req0_ready : bus.req1_ready, 0);
        @(posedge clk); #1;
        set_req(v.req, 1'b0, ~v.op, 32'h0, 32'h0);
        bus.fpu_result = v.result;
        hold_ok = 1'b1;
        got = 1'b0;
        k = 0;
        while (!got && k < 200) begin
            if (bus.fpu_operation !== v.op || bus.fpu_operand_1 !== v.a || bus.fpu_operand_2 !== v.b)
                hold_ok = 1'b0;
            bus.fpu_ready = (v.delay >= 0) && (k >= v.delay);
            @(posedge clk); #1;
            k++;
            got = bus.resp0_valid | bus.resp1_valid;
        end
        bus.fpu_ready = 1'b0;
        check("issue_hold", hold_ok, 1);
        check("latency", k + 1, v.lat);
        check("resp_owner", {bus.resp1_valid, bus.resp0_valid}, v.req ? 2'b10 : 2'b01);
        check("resp_data", bus.resp_data, v.data);
        check("resp_error", bus.resp_error, v.err);
        check("done_fpu_idle", {bus.fpu_operation, bus.fpu_operand_1, bus.fpu_operand_2}, 0);
        @(posedge clk); #1;
        check("flush_fpu", {bus.fpu_operation, bus.fpu_operand_1, bus.fpu_operand_2}, 0);
        check("flush_resp_low", {bus.resp1_valid, bus.resp0_valid}, 0);
        check("resp_hold", bus.resp_data, v.data);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, OP_ADD,  32'h0C00, 32'h0400, 0,  32'h1000, 2,  1'b0, 32'h1000};
        vecs[1] = '{1'b1, OP_MUL,  32'h0800, 32'h0C00, 6,  32'h0600, 8,  1'b0, 32'h0600};
        vecs[2] = '{1'b0, OP_SUB,  32'h1000, 32'h0400, 3,  32'h0C00, 5,  1'b0, 32'h0C00};
        vecs[3] = '{1'b1, OP_MUL,  32'h0400, 32'h0400, 0,  32'h1234, 3,  1'b0, 32'h1234};
        vecs[4] = '{1'b0, OP_SQRT, 32'h1000, 32'h0000, -1, 32'hDEAD, TIMEOUT + 1, 1'b1, 32'h0};
        vecs[5] = '{1'b1, OP_ADD,  32'h0055, 32'h0000, 0,  32'h0055, 2,  1'b0, 32'h0055};

        reset = 1'b0;
        set_req(1'b0, 1'b1, OP_MUL, 32'h11, 32'h22);
        set_req(1'b1, 1'b1, OP_SUB, 32'h33, 32'h44);
        bus.fpu_result = 32'hFFFF;
        bus.fpu_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", {bus.req1_ready, bus.req0_ready}, 0);
        check("rst_resp", {bus.resp1_valid, bus.resp0_valid, bus.resp_error}, 0);
        check("rst_data", bus.resp_data, 0);
        check("rst_fpu", {bus.fpu_operation, bus.fpu_operand_1, bus.fpu_operand_2}, 0);
        set_req(1'b0, 1'b0, OP_ADD, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, OP_ADD, 32'h0, 32'h0);
        bus.fpu_ready = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Both requesters hold valid: grants alternate, spaced by ISSUE/DONE/FLUSH.
        set_req(1'b0, 1'b1, OP_ADD, 32'h1, 32'h2);
        set_req(1'b1, 1'b1, OP_ADD, 32'h3, 32'h4);
        bus.fpu_ready  = 1'b1;
        bus.fpu_result = 32'hA5A5;
        #1;
        for (int n = 0; n < 4; n++) begin
            int w;
            w = 0;
            while (!(bus.req0_ready | bus.req1_ready) && w < 20) begin
                @(posedge clk); #1;
                w++;
            end
            check("alt_onehot", bus.req0_ready & bus.req1_ready, 0);
            check($sformatf("alt_grant%0d", n), bus.req1_ready, n % 2);
            if (n > 0) check("alt_gap", w, 3);
            @(posedge clk); #1;
        end
        set_req(1'b0, 1'b0, OP_ADD, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, OP_ADD, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        bus.fpu_ready = 1'b0;

        // Reset during a MUL in ISSUE, pointer pointing at req1 beforehand.
        set_req(1'b0, 1'b1, OP_MUL, 32'h0800, 32'h0C00);
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, OP_MUL, 32'h0800, 32'h0C00);
        @(posedge clk); #1;
        check("rstmid_issue_op", bus.fpu_operation, OP_MUL);
        set_req(1'b0, 1'b1, OP_ADD, 32'h7, 32'h8);
        set_req(1'b1, 1'b1, OP_ADD, 32'h9, 32'hA);
        bus.fpu_ready = 1'b1;
        reset = 1'b0;
        #1;
        check("rstmid_fpu", {bus.fpu_operation, bus.fpu_operand_1, bus.fpu_operand_2}, 0);
        check("rstmid_ready", {bus.req1_ready, bus.req0_ready}, 0);
        check("rstmid_resp", {bus.resp1_valid, bus.resp0_valid, bus.resp_error}, 0);
        check("rstmid_data", bus.resp_data, 0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            check("rstmid_no_pulse", {bus.resp1_valid, bus.resp0_valid}, 0);
        end
        reset = 1'b1;
        #1;
        check("post_rst_ptr", {bus.req1_ready, bus.req0_ready}, 2'b01);
        @(posedge clk); #1;
        check("post_rst_accept", {bus.fpu_operation, bus.fpu_operand_1}, {OP_ADD, 32'h7});
        set_req(1'b0, 1'b0, OP_ADD, 32'h0, 32'h0);
        set_req(1'b1, 1'b0, OP_ADD, 32'h0, 32'h0);
        repeat (4) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
